// File: rtl/alu_acc_sequencer_if.sv
// Command, ALU and result bundle between a command source, the combinational ALU and alu_acc_sequencer.
// The slave modport is the sequencer's view; the master modport is the surrounding datapath's view.
interface alu_acc_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [31:0] cmd_operand;
    logic [31:0] alu_input1;
    logic [31:0] alu_input2;
    logic [3:0]  alu_opcode;
    logic [63:0] alu_output1;
    logic [1:0]  alu_error;
    logic [31:0] acc;
    logic [31:0] acc_hi;
    logic        done;
    logic [1:0]  resp_error;
    logic [1:0]  err_sticky;

    modport master (
        output cmd_valid, cmd_opcode, cmd_operand, alu_output1, alu_error,
        input  cmd_ready, alu_input1, alu_input2, alu_opcode,
               acc, acc_hi, done, resp_error, err_sticky
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_operand, alu_output1, alu_error,
        output cmd_ready, alu_input1, alu_input2, alu_opcode,
               acc, acc_hi, done, resp_error, err_sticky
    );
endinterface

// File: rtl/alu_acc_sequencer.sv
// Command front-end and accumulator around the combinational ALU: acc <= acc OP operand after a settle delay.
// Optional macro ALU_ACC_SAT_EN: overflow saturates acc instead of capturing the wrapped result.
module alu_acc_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    alu_acc_sequencer_if.slave bus
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_EXEC  = 1'b1;
    localparam logic [3:0] OP_LAST  = 4'b1011;
    localparam logic [3:0] OP_NOOP  = 4'b1001;
    localparam logic [3:0] OP_LOAD  = 4'b1100;
    localparam logic [3:0] OP_CLEAR = 4'b1101;
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    logic [0:0]  state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [3:0]  cmd_reg, cmd_next;
    logic [31:0] alu_input1_reg, alu_input1_next;
    logic [31:0] alu_input2_reg, alu_input2_next;
    logic [3:0]  alu_opcode_reg, alu_opcode_next;
    logic [31:0] acc_reg, acc_next;
    logic [31:0] acc_hi_reg, acc_hi_next;
    logic        done_reg, done_next;
    logic [1:0]  resp_error_reg, resp_error_next;
    logic [1:0]  err_sticky_reg, err_sticky_next;

    logic        accept;
    logic        capture;
    logic [1:0]  cap_error;

    assign bus.cmd_ready  = (state_reg == ST_IDLE);
    assign accept         = bus.cmd_ready && bus.cmd_valid;
    assign capture        = (state_reg == ST_EXEC) && (cnt_reg == 4'd0);

    assign bus.alu_input1 = alu_input1_reg;
    assign bus.alu_input2 = alu_input2_reg;
    assign bus.alu_opcode = alu_opcode_reg;
    assign bus.acc        = acc_reg;
    assign bus.acc_hi     = acc_hi_reg;
    assign bus.done       = done_reg;
    assign bus.resp_error = resp_error_reg;
    assign bus.err_sticky = err_sticky_reg;

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        cmd_next        = cmd_reg;
        alu_input1_next = alu_input1_reg;
        alu_input2_next = alu_input2_reg;
        alu_opcode_next = alu_opcode_reg;
        acc_next        = acc_reg;
        acc_hi_next     = acc_hi_reg;
        done_next       = 1'b0;
        resp_error_next = resp_error_reg;
        err_sticky_next = err_sticky_reg;
        cap_error       = 2'b00;

        if (accept) begin
            state_next      = ST_EXEC;
            cnt_next        = CNT_INIT;
            cmd_next        = bus.cmd_opcode;
            alu_input1_next = bus.cmd_operand;
            alu_input2_next = acc_reg;
            // LOAD/CLEAR/illegal park the ALU on NOOP; the sequencer handles them itself
            alu_opcode_next = (bus.cmd_opcode <= OP_LAST) ? bus.cmd_opcode : OP_NOOP;
        end else if (state_reg == ST_EXEC && !capture) begin
            cnt_next = cnt_reg - 4'd1;
        end

        if (capture) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
            if (cmd_reg <= OP_LAST) begin
                case (bus.alu_error)
                    2'b00: begin
                        acc_next    = bus.alu_output1[31:0];
                        acc_hi_next = bus.alu_output1[63:32];
                    end
                    2'b01: begin
`ifdef ALU_ACC_SAT_EN
                        // acc is untouched during EXEC, so it still holds the pre-op value
                        acc_next    = acc_reg[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        acc_hi_next = 32'd0;
`else
                        acc_next    = bus.alu_output1[31:0];
                        acc_hi_next = bus.alu_output1[63:32];
`endif
                    end
                    default: ;
                endcase
                cap_error = bus.alu_error;
            end else if (cmd_reg == OP_LOAD) begin
                acc_next    = alu_input1_reg;
                acc_hi_next = 32'd0;
            end else if (cmd_reg == OP_CLEAR) begin
                acc_next    = 32'd0;
                acc_hi_next = 32'd0;
            end else begin
                cap_error = 2'b11;
            end

            resp_error_next = cap_error;
            err_sticky_next = (cmd_reg == OP_CLEAR) ? 2'b00 : (err_sticky_reg | cap_error);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= 4'd0;
            cmd_reg        <= OP_NOOP;
            alu_input1_reg <= 32'd0;
            alu_input2_reg <= 32'd0;
            alu_opcode_reg <= OP_NOOP;
            acc_reg        <= 32'd0;
            acc_hi_reg     <= 32'd0;
            done_reg       <= 1'b0;
            resp_error_reg <= 2'b00;
            err_sticky_reg <= 2'b00;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            cmd_reg        <= cmd_next;
            alu_input1_reg <= alu_input1_next;
            alu_input2_reg <= alu_input2_next;
            alu_opcode_reg <= alu_opcode_next;
            acc_reg        <= acc_next;
            acc_hi_reg     <= acc_hi_next;
            done_reg       <= done_next;
            resp_error_reg <= resp_error_next;
            err_sticky_reg <= err_sticky_next;
        end
    end
endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Directed bench for alu_acc_sequencer with a small ALU stand-in and an expected-result queue.
// Expected accumulator values follow ALU_ACC_SAT_EN when it is defined.
module tb_alu_acc_sequencer;
    localparam int unsigned SETTLE = 3;

    typedef struct {
        logic [31:0] acc;
        logic [31:0] hi;
        logic [1:0]  resp;
        logic [1:0]  sticky;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic [31:0] model_acc;
    exp_t sbq[$];

    alu_acc_sequencer_if bus();

    alu_acc_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU stand-in: a = input2 (accumulator), b = input1 (operand)
    logic [31:0] alu_a, alu_b, alu_d;
    logic [63:0] alu_sum;
    assign alu_a = bus.alu_input2;
    assign alu_b = bus.alu_input1;

    always_comb begin
        bus.alu_output1 = 64'd0;
        bus.alu_error   = 2'b00;
        alu_sum         = {32'd0, alu_a} + {32'd0, alu_b};
        alu_d           = alu_a - alu_b;
        case (bus.alu_opcode)
            4'b0000: begin
                bus.alu_output1 = alu_sum;
                if (alu_a[31] == alu_b[31] && alu_sum[31] != alu_a[31]) bus.alu_error = 2'b01;
            end
            4'b0001: begin
                bus.alu_output1 = {32'd0, alu_d};
                if (alu_a[31] != alu_b[31] && alu_d[31] != alu_a[31]) bus.alu_error = 2'b01;
            end
            4'b0010, 4'b0011: begin
                if (alu_b == 32'd0) begin
                    bus.alu_output1 = 64'hDEAD_BEEF_CAFE_F00D;
                    bus.alu_error   = 2'b10;
                end else if (bus.alu_opcode == 4'b0010) begin
                    bus.alu_output1 = {32'd0, alu_a / alu_b};
                end else begin
                    bus.alu_output1 = {32'd0, alu_a % alu_b};
                end
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [31:0] opd, input bit hold,
                           input logic [31:0] e_acc, input logic [31:0] e_hi,
                           input logic [1:0] e_resp, input logic [1:0] e_sticky);
        exp_t        e;
        exp_t        got;
        logic [3:0]  e_op;
        logic [31:0] e_in2;
        int          n;
        e_op  = (op <= 4'b1011) ? op : 4'b1001;
        e_in2 = model_acc;
        check("ready_idle", bus.cmd_ready, 1'b1);
        bus.cmd_valid   = 1'b1;
        bus.cmd_opcode  = op;
        bus.cmd_operand = opd;
        @(posedge clk); #1;
        e.acc = e_acc; e.hi = e_hi; e.resp = e_resp; e.sticky = e_sticky; e.cyc = cyc + SETTLE;
        sbq.push_back(e);
        if (hold) begin
            bus.cmd_opcode  = 4'b1101;
            bus.cmd_operand = 32'h5A5A_5A5A;
        end else begin
            bus.cmd_valid = 1'b0;
        end
        check("ready_exec", bus.cmd_ready, 1'b0);
        check("alu_in2", bus.alu_input2, e_in2);
        check("alu_opcode", bus.alu_opcode, e_op);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            check("alu_in1_held", bus.alu_input1, opd);
            @(posedge clk); #1;
            n++;
        end
        bus.cmd_valid = 1'b0;
        check("done_seen", bus.done, 1'b1);
        if (sbq.size() > 0) begin
            got = sbq.pop_front();
            check("done_cycle", cyc, got.cyc);
            check("acc", bus.acc, got.acc);
            check("acc_hi", bus.acc_hi, got.hi);
            check("resp_error", bus.resp_error, got.resp);
            check("err_sticky", bus.err_sticky, got.sticky);
        end
        model_acc = e_acc;
        @(posedge clk); #1;
        check("done_pulse_end", bus.done, 1'b0);
        $display("[TB] op=%b operand=%h -> acc=%h acc_hi=%h resp=%b sticky=%b",
                 op, opd, bus.acc, bus.acc_hi, bus.resp_error, bus.err_sticky);
    endtask

    initial begin
        logic [31:0] ovf_acc;
`ifdef ALU_ACC_SAT_EN
        ovf_acc = 32'h7FFF_FFFF;
`else
        ovf_acc = 32'h8000_0000;
`endif
        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_opcode  = 4'b0000;
        bus.cmd_operand = 32'd0;
        model_acc       = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc", bus.acc, 32'd0);
        check("rst_acc_hi", bus.acc_hi, 32'd0);
        check("rst_sticky", bus.err_sticky, 2'b00);
        check("rst_ready", bus.cmd_ready, 1'b1);
        check("rst_opcode", bus.alu_opcode, 4'b1001);
        check("rst_done", bus.done, 1'b0);
        check("rst_in1", bus.alu_input1, 32'd0);
        rst = 1'b0;

        run_cmd(4'b1100, 32'd5,          1'b0, 32'd5,          32'd0, 2'b00, 2'b00);
        run_cmd(4'b0000, 32'd3,          1'b1, 32'd8,          32'd0, 2'b00, 2'b00);
        run_cmd(4'b0001, 32'd2,          1'b0, 32'd6,          32'd0, 2'b00, 2'b00);
        run_cmd(4'b0000, 32'd2,          1'b0, 32'd8,          32'd0, 2'b00, 2'b00);
        run_cmd(4'b0010, 32'd0,          1'b0, 32'd8,          32'd0, 2'b10, 2'b10);
        run_cmd(4'b0011, 32'd3,          1'b0, 32'd2,          32'd0, 2'b00, 2'b10);
        run_cmd(4'b1101, 32'd77,         1'b0, 32'd0,          32'd0, 2'b00, 2'b00);
        run_cmd(4'b1100, 32'hFFFF_FFFF,  1'b0, 32'hFFFF_FFFF,  32'd0, 2'b00, 2'b00);
        run_cmd(4'b0000, 32'd1,          1'b0, 32'd0,          32'd1, 2'b00, 2'b00);
        run_cmd(4'b0010, 32'd0,          1'b0, 32'd0,          32'd1, 2'b10, 2'b10);
        run_cmd(4'b1101, 32'd0,          1'b0, 32'd0,          32'd0, 2'b00, 2'b00);
        run_cmd(4'b1100, 32'h7FFF_FFFF,  1'b0, 32'h7FFF_FFFF,  32'd0, 2'b00, 2'b00);
        run_cmd(4'b0000, 32'd1,          1'b0, ovf_acc,        32'd0, 2'b01, 2'b01);
        run_cmd(4'b1100, 32'd4,          1'b0, 32'd4,          32'd0, 2'b00, 2'b01);
        run_cmd(4'b1110, 32'd9,          1'b0, 32'd4,          32'd0, 2'b11, 2'b11);

        // Reset two edges into EXEC with a second command held on the bus
        bus.cmd_valid   = 1'b1;
        bus.cmd_opcode  = 4'b0000;
        bus.cmd_operand = 32'd1;
        @(posedge clk); #1;
        check("abort_ready", bus.cmd_ready, 1'b0);
        check("abort_in1", bus.alu_input1, 32'd1);
        bus.cmd_operand = 32'd11;
        @(posedge clk); #1;
        check("abort_done_t1", bus.done, 1'b0);
        check("abort_in1_held", bus.alu_input1, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_done_t2", bus.done, 1'b0);
        check("abort_acc", bus.acc, 32'd0);
        check("abort_sticky", bus.err_sticky, 2'b00);
        check("abort_resp", bus.resp_error, 2'b00);
        check("abort_ready_idle", bus.cmd_ready, 1'b1);
        check("abort_opcode", bus.alu_opcode, 4'b1001);
        check("abort_in2", bus.alu_input2, 32'd0);
        @(posedge clk); #1;
        check("abort_done_t3", bus.done, 1'b0);
        check("abort_no_accept", bus.alu_input1, 32'd0);
        rst       = 1'b0;
        model_acc = 32'd0;
        run_cmd(4'b0000, 32'd11,         1'b0, 32'd11,         32'd0, 2'b00, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
